// File: rtl/macc_stream.sv
// Streaming signed multiply-accumulate.
// Accumulates a*b over each tlast-delimited input frame and emits one
// rounded, shifted and (optionally) saturated result per frame.
// Stages: S1 operands -> S2 product -> S3 accumulate -> S4 round/shift ->
// output register. A single enable freezes every stage under backpressure.
module macc_stream #(
  parameter int ADW   = 24,
  parameter int BDW   = 18,
  parameter int ACCW  = 48,
  parameter int SHIFT = 0,
  parameter int ODW   = 24,
  parameter bit SAT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic signed [ADW-1:0]  s_axis_ta,
  input  logic signed [BDW-1:0]  s_axis_tb,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic signed [ODW-1:0]  m_axis_tdata,
  output logic                   m_axis_tovf
);

  localparam int PW = ADW + BDW;
  // One guard bit so the rounding add can never wrap.
  localparam int QW = ACCW + 1;
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [QW-1:0] RND = (QW'(1) << SHIFT) >> 1;

  generate
    if (ACCW < ADW + BDW) begin : g_bad_accw
      $error("macc_stream: ACCW must be >= ADW+BDW");
    end
    if (SHIFT < 0 || SHIFT > ACCW - 1) begin : g_bad_shift
      $error("macc_stream: SHIFT must lie in 0..ACCW-1");
    end
    if (ODW > ACCW - SHIFT) begin : g_bad_odw
      $error("macc_stream: ODW must be <= ACCW-SHIFT");
    end
    if (ODW < 2) begin : g_small_odw
      $error("macc_stream: ODW must be at least 2");
    end
  endgenerate

  // Global advance: the whole pipeline moves only when the output register
  // is empty or being drained this cycle.
  logic en;
  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en && !rst;

  // ---------------------------------------------------------------------
  // S1: operand registers
  // ---------------------------------------------------------------------
  logic                  s1_v;
  logic                  s1_last;
  logic signed [ADW-1:0] s1_a;
  logic signed [BDW-1:0] s1_b;

  // S1 valid: a beat enters whenever the stage advances with tvalid high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and process ordering cannot matter.
    if (rst) begin
      s1_v <= 1'b0;
    end else if (en) begin
      s1_v <= s_axis_tvalid;
    end
  end

  // S1 payload: captured only for real beats, so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    // NOTE: payload registers have no reset; the valid bits alongside them
    // qualify every use, so the reset tree only reaches control state.
    if (en && s_axis_tvalid) begin
      s1_a    <= s_axis_ta;
      s1_b    <= s_axis_tb;
      s1_last <= s_axis_tlast;
    end
  end

  // ---------------------------------------------------------------------
  // S2: full-precision product, sign-extended to the accumulator width
  // ---------------------------------------------------------------------
  logic                   s2_v;
  logic                   s2_last;
  logic signed [ACCW-1:0] s2_prod;
  logic signed [PW-1:0]   prod_full;

  assign prod_full = PW'(s1_a) * PW'(s1_b);

  // S2 valid follows S1 valid on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else if (en) begin
      s2_v <= s1_v;
    end
  end

  // S2 payload: product and frame marker of the beat held in S1.
  always_ff @(posedge clk) begin
    if (en && s1_v) begin
      s2_prod <= ACCW'(prod_full);
      s2_last <= s1_last;
    end
  end

  // ---------------------------------------------------------------------
  // S3: accumulator. Wraps modulo 2^ACCW; the first beat of a frame
  // restarts from zero instead of the previous frame's total.
  // ---------------------------------------------------------------------
  logic                   s3_v;
  logic                   s3_last;
  logic                   first;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_next;

  // Next accumulator value for the beat currently in S2.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, which
    // keeps latches from being inferred when branches are added later.
    acc_next = s2_prod;
    if (!first) begin
      acc_next = acc + s2_prod;
    end
  end

  // S3 control: valid tracking and the start-of-frame flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v  <= 1'b0;
      first <= 1'b1;
    end else if (en) begin
      s3_v <= s2_v;
      if (s2_v) begin
        first <= s2_last;
      end
    end
  end

  // S3 datapath: accumulate only real beats; bubbles leave acc intact.
  always_ff @(posedge clk) begin
    if (en && s2_v) begin
      acc     <= acc_next;
      s3_last <= s2_last;
    end
  end

  // ---------------------------------------------------------------------
  // S4: round half up and arithmetic shift, only for the frame's last beat
  // ---------------------------------------------------------------------
  logic                 rnd_v;
  logic signed [QW-1:0] rnd_sum;
  logic signed [QW-1:0] rnd_q;

  assign rnd_sum = $signed({acc[ACCW-1], acc}) + RND;

  // S4 valid: set only when S3 carries a completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_v <= 1'b0;
    end else if (en) begin
      rnd_v <= s3_v && s3_last;
    end
  end

  // S4 payload: shifted frame total.
  always_ff @(posedge clk) begin
    if (en && s3_v && s3_last) begin
      rnd_q <= rnd_sum >>> SHIFT;
    end
  end

  // ---------------------------------------------------------------------
  // Output: range check, optional clamp, result register
  // ---------------------------------------------------------------------
  logic [QW-ODW:0]       q_hi;
  logic                  out_ovf;
  logic signed [ODW-1:0] out_sat;
  logic signed [ODW-1:0] out_data;

  // The result fits in ODW bits exactly when all bits from the output sign
  // bit upward agree.
  always_comb begin
    q_hi     = rnd_q[QW-1:ODW-1];
    out_ovf  = !((&q_hi) || !(|q_hi));
    out_sat  = rnd_q[QW-1] ? {1'b1, {(ODW-1){1'b0}}} : {1'b0, {(ODW-1){1'b1}}};
    out_data = rnd_q[ODW-1:0];
    if (SAT && out_ovf) begin
      out_data = out_sat;
    end
  end

  // Output register: loads a new result or drains on handshake; holds still
  // while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tovf   <= 1'b0;
    end else if (en) begin
      m_axis_tvalid <= rnd_v;
      if (rnd_v) begin
        m_axis_tdata <= out_data;
        m_axis_tovf  <= out_ovf;
      end
    end
  end

endmodule

// File: doc/macc_stream.md
Name: macc_stream

Overview:
- Streaming signed multiply-accumulate with valid/ready handshakes and frame delimiting via tlast. Successor to the free-running ce/sload MAC core.
- Accumulates a*b over each input frame. On the last beat it emits one rounded, shifted and optionally saturated result.
- Sits between sample sources (FIR taps, dot-product feeders) and downstream stream consumers. Supports full backpressure.

Parameters:
- ADW, 24, signed width of operand a.
- BDW, 18, signed width of operand b.
- ACCW, 48, accumulator width. Must be >= ADW+BDW; elaboration error otherwise.
- SHIFT, 0, arithmetic right shift applied to the accumulator at output, with rounding. Range 0..ACCW-1.
- ODW, 24, output width. Must be <= ACCW-SHIFT.
- SAT, 1, 1 = saturate to ODW; 0 = truncate (two's-complement wrap).

Ports:
- clk, in, 1, clock. All logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, input beat accepted when tvalid&&tready.
- s_axis_ta, in, ADW, signed operand a.
- s_axis_tb, in, BDW, signed operand b.
- s_axis_tlast, in, 1, final beat of the frame.
- m_axis_tvalid, out, 1, result valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tdata, out, ODW, signed result.
- m_axis_tovf, out, 1, saturation or wrap occurred on this result.

Behaviour:
- Reset (clk edge with rst=1):
  - All stage valid bits clear; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tovf=0.
  - The first-beat flag is set, so the next beat starts a new frame. A partial frame is discarded; no output is produced for it.
- Global advance: en = !m_axis_tvalid || m_axis_tready. s_axis_tready = en and rst=0. s_axis_tready has no combinational path from s_axis_tvalid.
- Pipeline (all stages advance only when en=1; each stage carries a valid bit and a last bit):
  - S1 registers a, b, last.
  - S2 forms the product, ADW+BDW bits signed, sign-extended to ACCW.
  - S3 accumulates: acc <= (first ? 0 : acc) + prod. first <= last. Accumulation wraps modulo 2^ACCW with no accumulator saturation.
  - S4 is the output stage. Only when S3 holds a valid last beat:
    - r = acc + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed at ACCW+1 bits so the rounding add cannot wrap.
    - q = r >>> SHIFT.
    - SAT=1: clamp q to [-2^(ODW-1), 2^(ODW-1)-1]; tovf=1 if clamped.
    - SAT=0: take the low ODW bits; tovf=1 if q does not fit in ODW bits.
    - Load m_axis_tdata/tovf and set m_axis_tvalid.
- m_axis_tvalid clears on a handshake unless a new result loads in the same cycle. Back-to-back single-beat frames then produce one result per cycle.
- Latency: a tlast beat accepted at edge N gives m_axis_tvalid=1 after edge N+4 with no stalls. Throughput is 1 beat/cycle.
- Backpressure:
  - While m_axis_tvalid=1 and m_axis_tready=0, the whole pipeline freezes.
  - The accumulator and all stage registers hold. m_axis_tdata/tovf remain stable.
  - No beat is lost or duplicated.
- Bubbles: beats with tvalid=0 do not touch the accumulator. Idle gaps inside a frame are allowed and do not change the result.
- Single-beat frame (tlast on the first beat): result is round/sat(a*b).
- Beats with s_axis_tvalid=0 ignore ta, tb and tlast.
- rst asserted while m_axis_tvalid=1: the output is dropped.

Test Plan:
- Single beat, ADW=24/BDW=18/SHIFT=0/ODW=24:
  - Input a=3, b=-5, last=1 -> m_axis_tdata=-15, tovf=0.
  - m_axis_tvalid rises exactly 4 cycles after acceptance.
- Four-beat frame followed by a second frame:
  - Frame 1: a={1,2,3,4}, b={10,10,10,10}, last on beat 4 -> 100.
  - Frame 2: a=7, b=1, last=1 -> 7. Proves the accumulator clears between frames.
- Backpressure:
  - Hold m_axis_tready=0 for 6 cycles while 3 frames of 2 beats each stream in -> s_axis_tready drops.
  - Results {a0b0+a1b1,...} arrive in order after release, each held stable while stalled, with no loss.
- Rounding, SHIFT=4:
  - Accumulator 24 -> 2. Accumulator 23 -> 1. Accumulator -24 -> -1 (round half up: (-24+8)>>>4 = -1).
- Saturation, ODW=16, SHIFT=0, SAT=1:
  - Frame sum 40000 -> 32767, tovf=1.
  - Sum -40000 -> -32768, tovf=1.
  - With SAT=0, sum 40000 -> -25536, tovf=1.
- Reset mid-frame:
  - Accept 2 beats (a=5, b=5), assert rst for one cycle, then send a=1, b=1, last=1 -> output 1. No output for the aborted frame.
